// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Select-to-one-hot decode; sized for the widest supported channel count,
    // callers truncate to their own N.
    function automatic logic [15:0] sel_onehot(input logic [3:0] sel);
        sel_onehot = 16'd1 << sel;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Upstream stream plus fanned-out downstream channels of the demultiplexer.
interface stream_demux_if #(
    parameter int N = 8,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic [SW-1:0] in_sel;
    logic          in_bcast;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;

    modport master (
        output in_valid, in_data, in_last, in_sel, in_bcast, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_last, in_sel, in_bcast, out_ready,
        output in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/stream_demux_buf.sv
// One-entry output register; a beat retires once every channel in its
// pending mask has taken it.
module stream_demux_buf #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         last,
    input  logic [N-1:0] mask,
    input  logic [N-1:0] out_ready,
    output logic         free,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [N-1:0] out_valid
);
    logic [N-1:0] pending_q, pending_d, pending_left;
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;

    // Retire accepted channels; a new load replaces the mask outright.
    always_comb begin
        pending_left = pending_q & ~out_ready;
        free         = (pending_left == '0);
        pending_d    = load ? mask : pending_left;
        data_d       = load ? data : data_q;
        last_d       = load ? last : last_q;
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    assign out_valid = pending_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer: route latched on the first beat, optional
// broadcast, illegal destinations swallowed and counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux_if.slave bus,
    output logic [CW-1:0] drop_cnt,
    output logic          busy
);
    state_t        state_q, state_d;
    logic [N-1:0]  route_q, route_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic          buf_free, in_ready, accept, sel_legal, load;
    logic [N-1:0]  first_mask, load_mask;

    // Route decode, handshake and next-state logic.
    always_comb begin
        sel_legal  = bus.in_bcast | (32'(bus.in_sel) < N);
        first_mask = bus.in_bcast ? '1 : N'(sel_onehot(4'(bus.in_sel)));
        // Dropped beats never touch the buffer, so they need not wait on it.
        in_ready   = (state_q == ST_DROP) | buf_free;
        accept     = bus.in_valid & in_ready;

        state_d    = state_q;
        route_d    = route_q;
        drop_cnt_d = drop_cnt_q;
        load       = 1'b0;
        load_mask  = route_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_legal) begin
                        load      = 1'b1;
                        load_mask = first_mask;
                        route_d   = first_mask;
                        state_d   = bus.in_last ? ST_IDLE : ST_PKT;
                    end else begin
                        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                        state_d = bus.in_last ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_PKT: begin
                if (accept) begin
                    load = 1'b1;
                    if (bus.in_last) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && bus.in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, latched route and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            route_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    stream_demux_buf #(.N(N), .W(W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (bus.in_data),
        .last      (bus.in_last),
        .mask      (load_mask),
        .out_ready (bus.out_ready),
        .free      (buf_free),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .out_valid (bus.out_valid)
    );

    assign bus.in_ready = in_ready;
    assign drop_cnt     = drop_cnt_q;
    assign busy         = (state_q != ST_IDLE) | (bus.out_valid != '0);

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux (N=6 so that selects 6 and 7
// are illegal, CW=2 so drop counter saturation is reached).
module tb_stream_demux;
    localparam int N  = 6;
    localparam int W  = 8;
    localparam int CW = 2;
    localparam int SW = $clog2(N);
    localparam int NCYC = 4000;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] drop_cnt;
    logic          busy;

    stream_demux_if #(.N(N), .W(W)) bus ();

    stream_demux #(.N(N), .W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel queues of beats still owed to each consumer.
    beat_t        exp_q[N][$];
    bit           m_in_pkt;
    bit           m_drop;
    bit [N-1:0]   m_dests;
    int           m_cnt;
    bit           mon_en;
    int           n_vec;
    int           n_err;
    int           rst_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) exp_q[c].delete();
        m_in_pkt = 1'b0;
        m_drop   = 1'b0;
        m_dests  = '0;
        m_cnt    = 0;
    endtask

    task automatic model_accept();
        beat_t b;
        b.data = bus.in_data;
        b.last = bus.in_last;
        if (!m_in_pkt) begin
            m_drop  = 1'b0;
            m_dests = '0;
            if (bus.in_bcast) begin
                m_dests = '1;
            end else if (int'(bus.in_sel) < N) begin
                m_dests[bus.in_sel] = 1'b1;
            end else begin
                m_drop = 1'b1;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end
        for (int c = 0; c < N; c++)
            if (m_dests[c]) exp_q[c].push_back(b);
        m_in_pkt = !bus.in_last;
        if (bus.in_last) m_drop = 1'b0;
    endtask

    task automatic drive(input int cyc);
        int phase;
        if (cyc >= NCYC - 50) begin
            bus.in_valid  = 1'b0;
            bus.out_ready = '1;
            return;
        end
        bus.in_valid = ($urandom % 10) < 7;
        bus.in_data  = W'($urandom);
        bus.in_last  = ($urandom % 3) == 0;
        bus.in_sel   = SW'($urandom % 8);
        bus.in_bcast = ($urandom % 8) == 0;
        phase = (cyc / 400) % 3;
        for (int c = 0; c < N; c++) begin
            case (phase)
                0:       bus.out_ready[c] = 1'b1;
                1:       bus.out_ready[c] = ($urandom % 10) < 6;
                default: bus.out_ready[c] = ($urandom % 4) == 0;
            endcase
        end
    endtask

    // Monitor: compare DUT outputs to the model and retire delivered beats.
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_v;
        logic         exp_rdy;
        if (rst_n && mon_en) begin
            exp_v = '0;
            for (int c = 0; c < N; c++) exp_v[c] = (exp_q[c].size() != 0);
            check("out_valid", bus.out_valid, exp_v);
            for (int c = 0; c < N; c++) begin
                if (exp_v[c] && bus.out_valid[c]) begin
                    check("out_data", bus.out_data, exp_q[c][0].data);
                    check("out_last", bus.out_last, exp_q[c][0].last);
                end
            end
            exp_rdy = m_drop || ((exp_v & ~bus.out_ready) == '0);
            check("in_ready", bus.in_ready, exp_rdy);
            check("busy", busy, m_in_pkt || (exp_v != '0));
            check("drop_cnt", drop_cnt, m_cnt);
            for (int c = 0; c < N; c++)
                if (exp_v[c] && bus.out_ready[c]) void'(exp_q[c].pop_front());
        end
    end

    // Stimulus: random beats and ready patterns, with two asynchronous resets.
    initial begin
        n_vec = 0;
        n_err = 0;
        rst_hold = 0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_sel    = '0;
        bus.in_bcast  = 1'b0;
        bus.out_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            drive(cyc);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if (cyc == 1500 || cyc == 3000) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("midrst_out_valid", bus.out_valid, 0);
                check("midrst_busy", busy, 0);
                check("midrst_out_data", bus.out_data, 0);
                check("midrst_out_last", bus.out_last, 0);
                check("midrst_drop_cnt", drop_cnt, 0);
                rst_hold = 3;
            end
            @(negedge clk);
            #1;
            if (rst_n && bus.in_valid && bus.in_ready) model_accept();
        end

        for (int c = 0; c < N; c++) check("drain", exp_q[c].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
